// File: rtl/code_lock_amisha_pkg.sv
// Shared constants and helpers for the 2-bit-symbol code lock.
package code_lock_amisha_pkg;

    localparam int SYM_W   = 2;
    localparam int TIMER_W = 8;

    localparam logic [1:0] ST_ENTRY    = 2'd0;
    localparam logic [1:0] ST_UNLOCKED = 2'd1;
    localparam logic [1:0] ST_LOCKOUT  = 2'd2;

    // Symbol k of the packed code sits at bits [2k+1:2k].
    function automatic logic [SYM_W-1:0] code_sym(
        input logic [2*4-1:0] code,
        input logic [1:0]     idx
    );
        return code[{idx, 1'b0} +: SYM_W];
    endfunction

endpackage

// File: rtl/code_lock_amisha_eq2.sv
// Combinational 2-bit equality comparator.
module eq2_cmp_amisha
    import code_lock_amisha_pkg::*;
(
    input  logic [SYM_W-1:0] a_i,
    input  logic [SYM_W-1:0] b_i,
    output logic             eq_o
);

    assign eq_o = ~|(a_i ^ b_i);

endmodule

// File: rtl/code_lock_amisha.sv
// Code lock: per-symbol check, unlock window, lockout after repeated failures.
module code_lock_amisha
    import code_lock_amisha_pkg::*;
#(
    parameter int         CODE_LEN    = 4,
    parameter logic [7:0] CODE        = 8'b00_11_01_10,
    parameter int         MAX_FAIL    = 3,
    parameter int         UNLOCK_CYC  = 8,
    parameter int         LOCKOUT_CYC = 16
) (
    input  logic             clk_amisha,
    input  logic             rst_n_amisha,
    input  logic [SYM_W-1:0] sym_amisha,
    input  logic             sym_valid_amisha,
    output logic             sym_ready_amisha,
    input  logic             clear_amisha,
    output logic             unlocked_amisha,
    output logic             lockout_amisha,
    output logic             fail_pulse_amisha,
    output logic [1:0]       idx_amisha,
    output logic [1:0]       fail_cnt_amisha
);

    localparam logic [1:0]         LAST_IDX = 2'(CODE_LEN - 1);
    localparam logic [2:0]         MAX_F    = 3'(MAX_FAIL);
    localparam logic [TIMER_W-1:0] UNL_T    = TIMER_W'(UNLOCK_CYC - 1);
    localparam logic [TIMER_W-1:0] LCK_T    = TIMER_W'(LOCKOUT_CYC - 1);

    logic [1:0]         state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic               err_q, err_d;
    logic [1:0]         fail_cnt_q, fail_cnt_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               pulse_q, pulse_d;

    logic [SYM_W-1:0] exp_sym;
    logic             match;
    logic             accept;
    logic             final_err;
    logic             last_sym;
    logic [2:0]       fail_inc;

    assign exp_sym = code_sym(CODE, idx_q);

    eq2_cmp_amisha u_cmp (
        .a_i  (sym_amisha),
        .b_i  (exp_sym),
        .eq_o (match)
    );

    assign accept    = sym_valid_amisha & (state_q == ST_ENTRY);
    assign final_err = err_q | ~match;
    assign last_sym  = (idx_q == LAST_IDX);
    assign fail_inc  = {1'b0, fail_cnt_q} + 3'd1;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        err_d      = err_q;
        fail_cnt_d = fail_cnt_q;
        timer_d    = timer_q;
        pulse_d    = 1'b0;
        case (state_q)
            ST_ENTRY: begin
                if (clear_amisha) begin
                    idx_d = 2'd0;
                    err_d = 1'b0;
                end else if (accept) begin
                    if (last_sym) begin
                        idx_d = 2'd0;
                        err_d = 1'b0;
                        if (!final_err) begin
                            state_d    = ST_UNLOCKED;
                            timer_d    = UNL_T;
                            fail_cnt_d = 2'd0;
                        end else if (fail_inc < MAX_F) begin
                            fail_cnt_d = fail_inc[1:0];
                            pulse_d    = 1'b1;
                        end else begin
                            state_d    = ST_LOCKOUT;
                            timer_d    = LCK_T;
                            fail_cnt_d = MAX_F[1:0];
                            pulse_d    = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 2'd1;
                        err_d = final_err;
                    end
                end
            end
            ST_UNLOCKED: begin
                if (timer_q == '0) begin
                    state_d = ST_ENTRY;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d    = ST_ENTRY;
                    fail_cnt_d = 2'd0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                // Illegal encoding recovers to a clean entry state.
                state_d = ST_ENTRY;
                idx_d   = 2'd0;
                err_d   = 1'b0;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
        if (!rst_n_amisha) begin
            state_q    <= ST_ENTRY;
            idx_q      <= 2'd0;
            err_q      <= 1'b0;
            fail_cnt_q <= 2'd0;
            timer_q    <= '0;
            pulse_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            err_q      <= err_d;
            fail_cnt_q <= fail_cnt_d;
            timer_q    <= timer_d;
            pulse_q    <= pulse_d;
        end
    end

    assign sym_ready_amisha  = (state_q == ST_ENTRY);
    assign unlocked_amisha   = (state_q == ST_UNLOCKED);
    assign lockout_amisha    = (state_q == ST_LOCKOUT);
    assign fail_pulse_amisha = pulse_q;
    assign idx_amisha        = idx_q;
    assign fail_cnt_amisha   = fail_cnt_q;

endmodule

// File: tb/tb_code_lock_amisha.sv
// Directed and randomized checks of code_lock_amisha against a queue-based model.
module tb_code_lock_amisha;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] sym = 2'd0;
    logic       valid = 1'b0;
    logic       clear = 1'b0;
    logic       ready, unlocked, lockout, pulse;
    logic [1:0] idx, fail_cnt;

    int n_vec = 0;
    int n_err = 0;

    int code_a [4] = '{2, 1, 3, 0};
    int q [$];
    int fails = 0;
    int unl_left = 0;
    int lock_left = 0;
    bit m_pulse = 1'b0;

    always #5 clk = ~clk;

    code_lock_amisha dut (
        .clk_amisha        (clk),
        .rst_n_amisha      (rst_n),
        .sym_amisha        (sym),
        .sym_valid_amisha  (valid),
        .sym_ready_amisha  (ready),
        .clear_amisha      (clear),
        .unlocked_amisha   (unlocked),
        .lockout_amisha    (lockout),
        .fail_pulse_amisha (pulse),
        .idx_amisha        (idx),
        .fail_cnt_amisha   (fail_cnt)
    );

    task automatic model_reset();
        q.delete();
        fails = 0;
        unl_left = 0;
        lock_left = 0;
        m_pulse = 1'b0;
    endtask

    task automatic model_step(input bit v, input int s, input bit c);
        bit ok;
        m_pulse = 1'b0;
        if (unl_left > 0) begin
            unl_left--;
        end else if (lock_left > 0) begin
            lock_left--;
            if (lock_left == 0) fails = 0;
        end else if (c) begin
            q.delete();
        end else if (v) begin
            q.push_back(s);
            if (q.size() == 4) begin
                ok = 1'b1;
                foreach (q[i]) if (q[i] != code_a[i]) ok = 1'b0;
                q.delete();
                if (ok) begin
                    unl_left = 8;
                    fails = 0;
                end else begin
                    fails++;
                    m_pulse = 1'b1;
                    if (fails == 3) lock_left = 16;
                end
            end
        end
    endtask

    task automatic check(input string tag);
        logic       e_unl, e_lck, e_rdy;
        logic [1:0] e_idx, e_fc;
        e_unl = (unl_left > 0);
        e_lck = (lock_left > 0);
        e_rdy = !(e_unl || e_lck);
        e_idx = 2'(q.size());
        e_fc  = 2'(fails);
        n_vec++;
        assert (unlocked === e_unl) else begin
            n_err++;
            $error("FAIL %s unlocked: got %b exp %b", tag, unlocked, e_unl);
        end
        assert (lockout === e_lck) else begin
            n_err++;
            $error("FAIL %s lockout: got %b exp %b", tag, lockout, e_lck);
        end
        assert (ready === e_rdy) else begin
            n_err++;
            $error("FAIL %s ready: got %b exp %b", tag, ready, e_rdy);
        end
        assert (pulse === m_pulse) else begin
            n_err++;
            $error("FAIL %s fail_pulse: got %b exp %b", tag, pulse, m_pulse);
        end
        assert (idx === e_idx) else begin
            n_err++;
            $error("FAIL %s idx: got %0d exp %0d", tag, idx, e_idx);
        end
        assert (fail_cnt === e_fc) else begin
            n_err++;
            $error("FAIL %s fail_cnt: got %0d exp %0d", tag, fail_cnt, e_fc);
        end
    endtask

    task automatic cycle(input bit v, input int s, input bit c, input string tag);
        valid = v;
        sym = 2'(s);
        clear = c;
        @(posedge clk);
        model_step(v, s, c);
        #1;
        check(tag);
    endtask

    task automatic enter(input int s0, input int s1, input int s2, input int s3,
                         input string tag);
        cycle(1, s0, 0, tag);
        cycle(1, s1, 0, tag);
        cycle(1, s2, 0, tag);
        cycle(1, s3, 0, tag);
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        while ((unl_left > 0 || lock_left > 0) && guard < 40) begin
            cycle(0, 0, 0, tag);
            guard++;
        end
        assert (guard < 40) else begin
            n_err++;
            $error("FAIL %s drain_timeout: got %0d exp <40", tag, guard);
        end
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check(tag);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int s;
        model_reset();
        #12;
        check("reset");
        rst_n = 1'b1;
        cycle(0, 0, 0, "idle");

        enter(2, 1, 3, 0, "correct");
        repeat (10) cycle(0, 0, 0, "unlock_win");

        enter(2, 1, 3, 1, "wrong_last");
        cycle(0, 0, 0, "after_wrong");
        enter(0, 1, 3, 0, "early_mis");
        cycle(0, 0, 0, "after_early");
        enter(3, 3, 3, 3, "third_wrong");
        repeat (18) cycle(1, $urandom_range(0, 3), $urandom_range(0, 1), "lockout");
        enter(2, 1, 3, 0, "post_lock");
        drain("post_lock_drain");

        enter(2, 1, 3, 1, "pre_clear");
        cycle(1, 2, 0, "clr_a");
        cycle(1, 1, 0, "clr_b");
        cycle(1, 3, 1, "clr_hit");
        enter(2, 1, 3, 0, "after_clr");
        drain("clr_drain");

        for (int k = 0; k < 4; k++) begin
            for (int v = 0; v < 4; v++) begin
                for (int j = 0; j < 4; j++)
                    cycle(1, (j == k) ? v : code_a[j], 0, "cmp_sweep");
                drain("cmp_drain");
            end
        end

        enter(2, 1, 3, 0, "rst_unl");
        cycle(0, 0, 0, "rst_unl_wait");
        async_reset("rst_mid_unlock");
        repeat (3) cycle(0, 0, 0, "rst_unl_after");
        enter(2, 1, 3, 1, "rst_fc");
        cycle(1, 2, 0, "rst_e0");
        cycle(1, 1, 0, "rst_e1");
        async_reset("rst_mid_entry");
        repeat (3) cycle(0, 0, 0, "rst_entry_after");

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 1) == 1 && q.size() < 4)
                s = code_a[q.size()];
            else
                s = $urandom_range(0, 3);
            cycle($urandom_range(0, 3) != 0, s, $urandom_range(0, 15) == 0, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
